// File: rtl/arb_tcp_byte_packer.sv
// Word buffer between the readout arbiter and the SiTCP transmit port: buffers 32-bit words
// and serialises each one into four bytes. Optional macro TX_MSB_FIRST_EN sends the most significant byte first.
module arb_tcp_byte_packer #(
  parameter int DEPTH            = 512,
  parameter int AW               = 9,
  parameter int NEAR_FULL_MARGIN = 4
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic [31:0] DATA_IN,
  input  logic        WRITE_IN,
  output logic        READY_OUT,
  output logic [7:0]  TX_DATA,
  output logic        TX_WR,
  input  logic        TX_FULL,
  output logic        FIFO_FULL,
  output logic        FIFO_NEAR_FULL,
  output logic [31:0] WORD_COUNT,
  output logic [15:0] LOST_COUNT
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_NEAR  = (AW+1)'(DEPTH - NEAR_FULL_MARGIN);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic [31:0]   r_word_cnt;
  logic [15:0]   r_lost_cnt;
  state_t        r_state;
  logic [1:0]    r_idx;
  logic [31:0]   r_shift;

  logic          w_full;
  logic          w_near;
  logic          w_nonempty;
  logic          w_accept;
  logic          w_tx_wr;
  logic          w_pop;
  logic [31:0]   w_head;
  logic [7:0]    w_byte;

  always_comb begin
    w_full     = (r_count == LP_DEPTH);
    w_near     = (r_count >= LP_NEAR);
    w_nonempty = (r_count != '0);
    w_accept   = WRITE_IN & ~w_full;
    w_tx_wr    = (r_state == S_SHIFT) & ~TX_FULL;
    // Pop either from idle or on the last byte of a word, so back-to-back words have no bubble.
    w_pop      = w_nonempty & ((r_state == S_IDLE) | (w_tx_wr & (r_idx == 2'd3)));
    w_head     = r_mem[r_rd_ptr];
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
`ifdef TX_MSB_FIRST_EN
      2'd0: w_byte = r_shift[31:24];
      2'd1: w_byte = r_shift[23:16];
      2'd2: w_byte = r_shift[15:8];
      2'd3: w_byte = r_shift[7:0];
`else
      2'd0: w_byte = r_shift[7:0];
      2'd1: w_byte = r_shift[15:8];
      2'd2: w_byte = r_shift[23:16];
      2'd3: w_byte = r_shift[31:24];
`endif
      default: w_byte = 8'h00;
    endcase
  end

  // Storage array carries no reset; only the pointers define its valid contents.
  always_ff @(posedge BUS_CLK) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_word_cnt <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_ready <= ENABLE & ~w_near;
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (WRITE_IN && w_full && (r_lost_cnt != 16'hFFFF)) begin
        r_lost_cnt <= r_lost_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_idx   <= 2'd0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_tx_wr) begin
            if (r_idx == 2'd3) begin
              r_idx <= 2'd0;
              if (w_nonempty) begin
                r_shift <= w_head;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign READY_OUT      = r_ready;
  assign TX_WR          = w_tx_wr;
  assign TX_DATA        = (r_state == S_SHIFT) ? w_byte : 8'h00;
  assign FIFO_FULL      = w_full;
  assign FIFO_NEAR_FULL = w_near;
  assign WORD_COUNT     = r_word_cnt;
  assign LOST_COUNT     = r_lost_cnt;

endmodule

// File: tb/tb_arb_tcp_byte_packer.sv
// Bench for arb_tcp_byte_packer: byte-stream scoreboard plus directed and random steps.
module tb_arb_tcp_byte_packer;
  localparam int DEPTH  = 512;
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] din;
  logic        wr;
  logic        full;
  logic        ready_out;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        fifo_full;
  logic        fifo_near;
  logic [31:0] word_count;
  logic [15:0] lost_count;

  arb_tcp_byte_packer #(.DEPTH(DEPTH), .AW(9), .NEAR_FULL_MARGIN(MARGIN)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en), .DATA_IN(din), .WRITE_IN(wr),
    .READY_OUT(ready_out), .TX_DATA(tx_data), .TX_WR(tx_wr), .TX_FULL(full),
    .FIFO_FULL(fifo_full), .FIFO_NEAR_FULL(fifo_near),
    .WORD_COUNT(word_count), .LOST_COUNT(lost_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned wc_exp = 0;
  int unsigned lost_exp = 0;
  int          cyc_no = 0;
  int          tx_total = 0;
  int          first_tx = -1;
  int          last_tx = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
`ifdef TX_MSB_FIRST_EN
    return w[8*(3-i) +: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  task automatic push_bytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(w, i));
  endtask

  always @(posedge clk) cyc_no++;

  // Scoreboard: every emitted byte must be the next byte of the accepted word stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (full) chk("wr_while_full", {31'd0, tx_wr}, 32'd0);
      if (full && exp_q.size() > 0 && tx_data !== 8'h00)
        chk("stall_hold", {24'd0, tx_data}, {24'd0, exp_q[0]});
      if (tx_wr) begin
        tx_total++;
        if (first_tx < 0) first_tx = cyc_no;
        last_tx = cyc_no;
        if (exp_q.size() == 0) chk("spurious_byte", {31'd0, tx_wr}, 32'd0);
        else chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input bit acc);
    wr  = 1'b1;
    din = d;
    if (acc) begin
      push_bytes(d);
      wc_exp++;
    end else if (lost_exp < 65535) begin
      lost_exp++;
    end
    cyc();
    wr = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
    repeat (3) cyc();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_out}, 32'd0);
    chk({tag, "_txwr"},  {31'd0, tx_wr}, 32'd0);
    chk({tag, "_txdat"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_full"},  {31'd0, fifo_full}, 32'd0);
    chk({tag, "_near"},  {31'd0, fifo_near}, 32'd0);
    chk({tag, "_wcnt"},  word_count, 32'd0);
    chk({tag, "_lost"},  {16'd0, lost_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    int          base;
    rst = 1'b1; en = 1'b0; wr = 1'b0; full = 1'b0; din = '0;
    #12;
    chk_reset_outputs("reset");
    #1 rst = 1'b0;
    en = 1'b1;
    cyc();

    // Single word: first byte in the second cycle after acceptance.
    w = 32'h44332211;
    put(w, 1'b1);
    @(negedge clk);
    chk("lat_idle", {31'd0, tx_wr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_wr", {31'd0, tx_wr}, 32'd1);
      chk("lat_byte", {24'd0, tx_data}, {24'd0, byte_of(w, i)});
    end
    @(negedge clk);
    chk("lat_after", {31'd0, tx_wr}, 32'd0);
    chk("lat_idle_data", {24'd0, tx_data}, 32'd0);
    cyc();
    chk("lat_wcnt", word_count, wc_exp);
    chk("lat_near", {31'd0, fifo_near}, 32'd0);
    chk("lat_ready", {31'd0, ready_out}, 32'd1);

    // Eight back-to-back words must stream as 32 gapless bytes.
    base = tx_total;
    first_tx = -1;
    for (int i = 0; i < 8; i++) put($urandom, 1'b1);
    repeat (50) cyc();
    chk("b2b_bytes", tx_total - base, 32'd32);
    chk("b2b_span", last_tx - first_tx + 1, 32'd32);
    chk("b2b_empty", exp_q.size(), 32'd0);

    // Backpressure toggling every cycle during a two-word transfer.
    full = 1'b1;
    put($urandom | 32'h01010101, 1'b1);
    put($urandom | 32'h01010101, 1'b1);
    for (int i = 0; i < 24; i++) begin
      full = ~full;
      cyc();
    end
    full = 1'b0;
    drain(40, "toggle_drain");

    // Fill with the transmitter blocked; the first word sits in the serialiser, not the buffer.
    full = 1'b1;
    for (int i = 0; i < DEPTH - MARGIN; i++) put($urandom, 1'b1);
    chk("fill_near_lo", {31'd0, fifo_near}, 32'd0);
    put($urandom, 1'b1);
    chk("fill_near_hi", {31'd0, fifo_near}, 32'd1);
    chk("fill_ready_lag", {31'd0, ready_out}, 32'd1);
    cyc();
    chk("fill_ready_drop", {31'd0, ready_out}, 32'd0);
    for (int i = 0; i < MARGIN - 1; i++) put($urandom, 1'b1);
    chk("fill_not_full", {31'd0, fifo_full}, 32'd0);
    put($urandom, 1'b1);
    chk("fill_full", {31'd0, fifo_full}, 32'd1);
    for (int i = 0; i < 3; i++) put($urandom, 1'b0);
    chk("fill_lost", {16'd0, lost_count}, lost_exp);
    chk("fill_wcnt", word_count, wc_exp);
    full = 1'b0;
    drain(3000, "fill_drain");
    chk("fill_clr_full", {31'd0, fifo_full}, 32'd0);
    chk("fill_clr_near", {31'd0, fifo_near}, 32'd0);
    chk("fill_ready_back", {31'd0, ready_out}, 32'd1);

    // Random writes, backpressure and ENABLE; the buffer never nears full here.
    for (int i = 0; i < 300; i++) begin
      chk("rnd_ready", {31'd0, ready_out}, {31'd0, en});
      en   = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wr  = 1'b1;
        din = $urandom;
        push_bytes(din);
        wc_exp++;
      end else begin
        wr = 1'b0;
      end
      cyc();
    end
    wr = 1'b0; full = 1'b0; en = 1'b1;
    drain(2000, "rnd_drain");
    chk("rnd_wcnt", word_count, wc_exp);

    // Asynchronous reset after the second byte of a word.
    put(32'h8899AABB, 1'b1);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      if (tx_wr) n++;
    end
    chk("rst_two_bytes", n, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    wc_exp = 0;
    lost_exp = 0;
    cyc();
    cyc();
    #3 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_wr) n++;
    end
    chk("rst_quiet", n, 32'd0);
    cyc();
    w = 32'hA5A5_0001;
    put(w, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_wr", {31'd0, tx_wr}, 32'd1);
      chk("post_rst_byte", {24'd0, tx_data}, {24'd0, byte_of(w, i)});
    end
    drain(20, "post_rst_drain");
    chk("post_rst_wcnt", word_count, wc_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
